// File: rtl/axi_uart_slave.sv
// AXI-Lite style register front end for a byte UART: RX/TX byte FIFOs behind a
// four-register map, with independent single-outstanding write and read engines.

module axi_uart_slave_fifo #(
  parameter int nb = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       push_ok
);
  localparam int DEPTH = 1 << nb;
  localparam logic [nb-1:0] PTR_ONE = nb'(1);
  localparam logic [nb:0]   CNT_ONE = (nb + 1)'(1);

  logic [7:0]    mem [DEPTH];
  logic [nb-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [nb:0]   cnt_reg;
  logic          do_push, do_pop;

  // Count saturates at DEPTH, so its top bit alone means full.
  assign empty   = (cnt_reg == '0);
  assign full    = cnt_reg[nb];
  assign do_pop  = pop & ~empty;
  assign push_ok = ~full | do_pop;
  assign do_push = push & push_ok;
  assign dout    = empty ? 8'h00 : mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_reg <= cnt_reg + CNT_ONE;
        2'b01:   cnt_reg <= cnt_reg - CNT_ONE;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= din;
  end
endmodule

module axi_uart_slave #(
  parameter int nbfifo = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  awadr,
  input  logic        awvld,
  output logic        awrdy,
  input  logic [31:0] wdat,
  input  logic        wvld,
  output logic        wrdy,
  output logic [1:0]  bresp,
  output logic        bvld,
  input  logic        brdy,
  input  logic [3:0]  aradr,
  input  logic        arvld,
  output logic        arrdy,
  output logic [31:0] rdat,
  output logic        rvld,
  input  logic        rrdy,
  input  logic [7:0]  rx_data,
  input  logic        rx_wr,
  output logic [7:0]  tx_data,
  input  logic        tx_rd,
  output logic        tx_vld
);
  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_STAT   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;
  localparam int RX = 0;
  localparam int TX = 1;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic        w_accept, r_accept;
  logic [1:0]  w_sel, r_sel;
  logic [1:0]  bresp_reg;
  logic [31:0] rdat_reg, rdat_next;
  logic        flush_tx_reg, flush_rx_reg;

  logic [1:0] fifo_push, fifo_pop, fifo_flush;
  logic [1:0] fifo_empty, fifo_full, fifo_push_ok;
  logic [7:0] fifo_din  [2];
  logic [7:0] fifo_dout [2];

  assign w_sel = awadr[3:2];
  assign r_sel = aradr[3:2];

  // Index RX feeds from the local side and drains to AXI reads; TX the reverse.
  assign fifo_push[RX]  = rx_wr;
  assign fifo_din[RX]   = rx_data;
  assign fifo_pop[RX]   = r_accept && (r_sel == REG_RXDATA);
  assign fifo_flush[RX] = flush_rx_reg;
  assign fifo_push[TX]  = w_accept && (w_sel == REG_TXDATA);
  assign fifo_din[TX]   = wdat[7:0];
  assign fifo_pop[TX]   = tx_rd;
  assign fifo_flush[TX] = flush_tx_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      axi_uart_slave_fifo #(.nb(nbfifo)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (fifo_flush[gi]),
        .push    (fifo_push[gi]),
        .din     (fifo_din[gi]),
        .pop     (fifo_pop[gi]),
        .dout    (fifo_dout[gi]),
        .empty   (fifo_empty[gi]),
        .full    (fifo_full[gi]),
        .push_ok (fifo_push_ok[gi])
      );
    end
  endgenerate

  assign tx_data = fifo_dout[TX];
  assign tx_vld  = ~fifo_empty[TX];

  // Write engine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state_reg <= W_IDLE;
    else      w_state_reg <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE: if (awvld && wvld) w_state_next = W_RESP;
      W_RESP: if (brdy)          w_state_next = W_IDLE;
    endcase
  end

  // Ready is combinational in idle, so it must also be held off during reset.
  always_comb begin
    w_accept = 1'b0;
    bvld     = 1'b0;
    case (w_state_reg)
      W_IDLE: w_accept = rst & awvld & wvld;
      W_RESP: bvld     = 1'b1;
    endcase
  end

  assign awrdy = w_accept;
  assign wrdy  = w_accept;
  assign bresp = bresp_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bresp_reg    <= 2'b00;
      flush_tx_reg <= 1'b0;
      flush_rx_reg <= 1'b0;
    end else begin
      flush_tx_reg <= w_accept && (w_sel == REG_CTRL) && wdat[0];
      flush_rx_reg <= w_accept && (w_sel == REG_CTRL) && wdat[1];
      if (w_accept)
        bresp_reg <= ((w_sel == REG_TXDATA) && !fifo_push_ok[TX]) ? 2'b10 : 2'b00;
    end
  end

  // Read engine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state_reg <= R_IDLE;
    else      r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE: if (arvld) r_state_next = R_DATA;
      R_DATA: if (rrdy)  r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    r_accept = 1'b0;
    rvld     = 1'b0;
    case (r_state_reg)
      R_IDLE: r_accept = rst & arvld;
      R_DATA: rvld     = 1'b1;
    endcase
  end

  assign arrdy = r_accept;
  assign rdat  = rdat_reg;

  always_comb begin
    rdat_next = 32'h0;
    case (r_sel)
      REG_RXDATA: rdat_next = {24'h0, fifo_dout[RX]};
      REG_STAT:   rdat_next = {28'h0, fifo_full[TX], fifo_empty[TX],
                               fifo_full[RX], ~fifo_empty[RX]};
      default:    rdat_next = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          rdat_reg <= 32'h0;
    else if (r_accept) rdat_reg <= rdat_next;
  end
endmodule

// File: tb/tb_axi_uart_slave.sv
// Directed bench for axi_uart_slave: register map, FIFO boundaries, backpressure,
// flushes and reset during an open write response.

module tb_axi_uart_slave;
  logic        clk;
  logic        rst;
  logic [3:0]  awadr;
  logic        awvld;
  logic        awrdy;
  logic [31:0] wdat;
  logic        wvld;
  logic        wrdy;
  logic [1:0]  bresp;
  logic        bvld;
  logic        brdy;
  logic [3:0]  aradr;
  logic        arvld;
  logic        arrdy;
  logic [31:0] rdat;
  logic        rvld;
  logic        rrdy;
  logic [7:0]  rx_data;
  logic        rx_wr;
  logic [7:0]  tx_data;
  logic        tx_rd;
  logic        tx_vld;

  int checks   = 0;
  int failures = 0;

  axi_uart_slave #(.nbfifo(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .awadr   (awadr),
    .awvld   (awvld),
    .awrdy   (awrdy),
    .wdat    (wdat),
    .wvld    (wvld),
    .wrdy    (wrdy),
    .bresp   (bresp),
    .bvld    (bvld),
    .brdy    (brdy),
    .aradr   (aradr),
    .arvld   (arvld),
    .arrdy   (arrdy),
    .rdat    (rdat),
    .rvld    (rvld),
    .rrdy    (rrdy),
    .rx_data (rx_data),
    .rx_wr   (rx_wr),
    .tx_data (tx_data),
    .tx_rd   (tx_rd),
    .tx_vld  (tx_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    awadr = a; wdat = d; awvld = 1'b1; wvld = 1'b1; brdy = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(awrdy && wrdy) && n < 20) begin n++; @(negedge clk); end
    check("aw_w_ready", {30'h0, awrdy, wrdy}, 32'h3);
    @(posedge clk); #1;
    awvld = 1'b0; wvld = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bvld && n < 20) begin n++; @(negedge clk); end
    check("bvld", 32'(bvld), 32'h1);
    resp = bresp;
    @(posedge clk); #1;
    brdy = 1'b0;
    $display("wr addr=0x%h data=0x%08h bresp=%b", a, d, resp);
  endtask

  task automatic axi_read(input logic [3:0] a, input int hold, output logic [31:0] d);
    int n;
    aradr = a; arvld = 1'b1; rrdy = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!arrdy && n < 20) begin n++; @(negedge clk); end
    check("arrdy", 32'(arrdy), 32'h1);
    @(posedge clk); #1;
    arvld = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvld && n < 20) begin n++; @(negedge clk); end
    check("rvld", 32'(rvld), 32'h1);
    d = rdat;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rvld_arrdy", {30'h0, rvld, arrdy}, 32'h2);
      check("hold_rdat", rdat, d);
    end
    rrdy = 1'b1;
    @(posedge clk); #1;
    rrdy = 1'b0;
    check("rvld_clear", 32'(rvld), 32'h0);
    $display("rd addr=0x%h rdat=0x%08h hold=%0d", a, d, hold);
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_wr = 1'b1;
    @(posedge clk); #1;
    rx_wr = 1'b0;
    $display("rx push 0x%02h", b);
  endtask

  logic [31:0] rd;
  logic [1:0]  resp;

  initial begin
    rst = 1'b0;
    awadr = '0; awvld = 1'b1; wdat = '0; wvld = 1'b1; brdy = 1'b0;
    aradr = '0; arvld = 1'b1; rrdy = 1'b0;
    rx_data = '0; rx_wr = 1'b0; tx_rd = 1'b0;

    // Reset state, with requests pending on every channel
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready_valid", {26'h0, awrdy, wrdy, arrdy, bvld, rvld, tx_vld}, 32'h0);
    check("rst_bresp", 32'(bresp), 32'h0);
    check("rst_rdat", rdat, 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    awvld = 1'b0; wvld = 1'b0; arvld = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Local RX push then read back through STAT/RXDATA
    rx_push(8'h41);
    axi_read(4'h8, 0, rd); check("stat_rx_one", rd, 32'h5);
    axi_read(4'h0, 0, rd); check("rxdata_41", rd, 32'h41);
    axi_read(4'h8, 0, rd); check("stat_after_pop", rd, 32'h4);

    // RXDATA read on empty RX
    axi_read(4'h0, 0, rd); check("rxdata_empty", rd, 32'h0);
    axi_read(4'h8, 0, rd); check("stat_unchanged", rd, 32'h4);
    axi_read(4'h4, 0, rd); check("read_txdata_zero", rd, 32'h0);
    axi_read(4'hC, 0, rd); check("read_ctrl_zero", rd, 32'h0);

    // Fill TX, overflow, then drain locally
    for (int i = 0; i < 16; i++) begin
      axi_write(4'h4, 32'(i), resp);
      check("tx_fill_bresp", 32'(resp), 32'h0);
    end
    axi_read(4'h8, 0, rd); check("stat_tx_full", rd, 32'h8);
    axi_write(4'h4, 32'h10, resp); check("tx_overflow_bresp", 32'(resp), 32'h2);
    for (int i = 0; i < 16; i++) begin
      check("tx_vld", 32'(tx_vld), 32'h1);
      check("tx_data_order", 32'(tx_data), 32'(i));
      tx_rd = 1'b1;
      @(posedge clk); #1;
      tx_rd = 1'b0;
    end
    check("tx_drained", 32'(tx_vld), 32'h0);
    tx_rd = 1'b1;
    @(posedge clk); #1;
    tx_rd = 1'b0;
    axi_read(4'h8, 0, rd); check("stat_tx_empty_pop", rd, 32'h4);

    // Writes to read-only registers
    axi_write(4'h0, 32'hFF, resp); check("wr_rxdata_resp", 32'(resp), 32'h0);
    axi_write(4'h8, 32'hFF, resp); check("wr_stat_resp", 32'(resp), 32'h0);
    axi_read(4'h8, 0, rd); check("stat_after_ro_wr", rd, 32'h4);

    // Read backpressure
    rx_push(8'h5A);
    axi_read(4'h8, 5, rd); check("hold_stat", rd, 32'h5);
    axi_read(4'h0, 0, rd); check("hold_then_rxdata", rd, 32'h5A);

    // RX full, dropped push, and RX flush
    for (int i = 0; i < 16; i++) rx_push(8'(8'h80 + i));
    axi_read(4'h8, 0, rd); check("stat_rx_full", rd, 32'h7);
    rx_push(8'hEE);
    axi_read(4'h0, 0, rd); check("rx_full_head", rd, 32'h80);
    axi_read(4'h8, 0, rd); check("stat_rx_not_full", rd, 32'h5);
    axi_write(4'hC, 32'h2, resp); check("ctrl_resp", 32'(resp), 32'h0);
    axi_read(4'h8, 0, rd); check("stat_rx_flushed", rd, 32'h4);

    // Three RX bytes then flush RX
    rx_push(8'h01); rx_push(8'h02); rx_push(8'h03);
    axi_read(4'h8, 0, rd); check("stat_rx_three", rd, 32'h5);
    axi_write(4'hC, 32'h2, resp);
    axi_read(4'h8, 0, rd); check("stat_rx3_flushed", rd, 32'h4);

    // TX flush
    axi_write(4'h4, 32'hA1, resp);
    axi_write(4'h4, 32'hA2, resp);
    axi_read(4'h8, 0, rd); check("stat_tx_two", rd, 32'h0);
    check("tx_head_a1", 32'(tx_data), 32'hA1);
    axi_write(4'hC, 32'h1, resp);
    axi_read(4'h8, 0, rd); check("stat_tx_flushed", rd, 32'h4);
    check("tx_vld_flushed", 32'(tx_vld), 32'h0);

    // Reset asserted while a write response is outstanding
    awadr = 4'h4; wdat = 32'h77; awvld = 1'b1; wvld = 1'b1; brdy = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 20 && !awrdy; n++) @(negedge clk);
    check("rst_wr_awrdy", 32'(awrdy), 32'h1);
    @(posedge clk); #1;
    awvld = 1'b0; wvld = 1'b0;
    @(negedge clk);
    check("rst_wr_bvld_open", 32'(bvld), 32'h1);
    #2 rst = 1'b0;
    #1 check("rst_bvld_immediate", 32'(bvld), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_bvld_after_rst", 32'(bvld), 32'h0);
    end
    check("tx_empty_after_rst", 32'(tx_vld), 32'h0);
    @(posedge clk); #1;
    axi_read(4'h8, 0, rd); check("stat_after_rst", rd, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
